// File: rtl/adpll_pfd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adpll_pfd_ctrl
// Brief    : ADPLL phase/frequency detector with binary-search acquisition
//            and +/-1 tracking of the DCO control word.
// Revision : 1.0 - initial release
// ============================================================================
module adpll_pfd_ctrl #(
    parameter int CODE_W   = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ref_clk,
    input  logic              fb_clk,
    output logic [CODE_W-1:0] dco_code,
    output logic              up,
    output logic              dn,
    output logic              acq_done,
    output logic              locked
);

    localparam logic [CODE_W-1:0] C_ONE      = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [CODE_W-1:0] C_CODE_RST = C_ONE << (CODE_W-1);
    localparam logic [CODE_W-1:0] C_STEP_RST = C_ONE << (CODE_W-2);
    localparam logic [CODE_W-1:0] C_CODE_MAX = {CODE_W{1'b1}};
    localparam logic [3:0]        C_LOCK     = 4'(LOCK_CNT);

    // Direction encoding shared by the previous-direction register
    localparam logic [1:0] C_DIR_NONE = 2'b00;
    localparam logic [1:0] C_DIR_UP   = 2'b10;
    localparam logic [1:0] C_DIR_DN   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REF_LEAD = 2'd1,
        S_FB_LEAD  = 2'd2
    } pfd_state_t;

    typedef enum logic {
        C_ACQ   = 1'b0,
        C_TRACK = 1'b1
    } ctl_state_t;

    logic [2:0]        r_ref_sync;
    logic [2:0]        r_fb_sync;
    logic              w_ref_edge;
    logic              w_fb_edge;

    pfd_state_t        r_pfd, w_pfd_nxt;
    logic              w_res_up, w_res_dn, w_res_al;
    logic              r_up, r_dn;

    ctl_state_t        r_ctl, w_ctl_nxt;
    logic [CODE_W-1:0] r_code, w_code_nxt;
    logic [CODE_W-1:0] r_step, w_step_nxt;
    logic [1:0]        r_prev, w_prev_nxt;
    logic [3:0]        r_lock_cnt, w_lock_cnt_nxt;
    logic              r_locked;
    logic              w_same_dir;
    logic [3:0]        w_lock_inc;

    // ------------------------------------------------------------------
    // Input synchronisers: [0],[1] synchronise, [2] holds history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_sync <= 3'b000;
            r_fb_sync  <= 3'b000;
        end else begin
            r_ref_sync <= {r_ref_sync[1:0], ref_clk};
            r_fb_sync  <= {r_fb_sync[1:0], fb_clk};
        end
    end

    assign w_ref_edge = r_ref_sync[1] & ~r_ref_sync[2];
    assign w_fb_edge  = r_fb_sync[1]  & ~r_fb_sync[2];

    // ------------------------------------------------------------------
    // PFD state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pfd <= S_IDLE;
            r_up  <= 1'b0;
            r_dn  <= 1'b0;
        end else begin
            r_pfd <= w_pfd_nxt;
            r_up  <= w_res_up;
            r_dn  <= w_res_dn;
        end
    end

    always_comb begin
        w_pfd_nxt = r_pfd;
        w_res_up  = 1'b0;
        w_res_dn  = 1'b0;
        w_res_al  = 1'b0;
        case (r_pfd)
            S_IDLE: begin
                if (w_ref_edge && w_fb_edge) begin
                    w_res_al = 1'b1;
                end else if (w_ref_edge) begin
                    w_pfd_nxt = S_REF_LEAD;
                end else if (w_fb_edge) begin
                    w_pfd_nxt = S_FB_LEAD;
                end
            end
            S_REF_LEAD: begin
                // A fresh ref edge closes the old window and opens a new one
                if (w_fb_edge) begin
                    w_res_up  = 1'b1;
                    w_pfd_nxt = w_ref_edge ? S_REF_LEAD : S_IDLE;
                end else if (w_ref_edge) begin
                    w_res_up  = 1'b1;
                end
            end
            S_FB_LEAD: begin
                if (w_ref_edge) begin
                    w_res_dn  = 1'b1;
                    w_pfd_nxt = w_fb_edge ? S_FB_LEAD : S_IDLE;
                end else if (w_fb_edge) begin
                    w_res_dn  = 1'b1;
                end
            end
            default: w_pfd_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state machine: acquisition, tracking and lock detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctl      <= C_ACQ;
            r_code     <= C_CODE_RST;
            r_step     <= C_STEP_RST;
            r_prev     <= C_DIR_NONE;
            r_lock_cnt <= 4'd0;
            r_locked   <= 1'b0;
        end else begin
            r_ctl      <= w_ctl_nxt;
            r_code     <= w_code_nxt;
            r_step     <= w_step_nxt;
            r_prev     <= w_prev_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= (r_lock_cnt == C_LOCK);
        end
    end

    assign w_same_dir = ((r_prev == C_DIR_UP) && w_res_up) ||
                        ((r_prev == C_DIR_DN) && w_res_dn);
    assign w_lock_inc = (r_lock_cnt >= C_LOCK) ? C_LOCK : r_lock_cnt + 4'd1;

    always_comb begin
        w_ctl_nxt      = r_ctl;
        w_code_nxt     = r_code;
        w_step_nxt     = r_step;
        w_prev_nxt     = r_prev;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_ctl)
            C_ACQ: begin
                if (w_res_up || w_res_dn) begin
                    w_code_nxt = w_res_up ? r_code + r_step : r_code - r_step;
                    w_step_nxt = r_step >> 1;
                    if (r_step == C_ONE) begin
                        w_ctl_nxt  = C_TRACK;
                        w_prev_nxt = C_DIR_NONE;
                    end
                end else if (w_res_al) begin
                    w_ctl_nxt  = C_TRACK;
                    w_prev_nxt = C_DIR_NONE;
                end
            end
            C_TRACK: begin
                if (w_res_up) begin
                    if (r_code != C_CODE_MAX) w_code_nxt = r_code + C_ONE;
                end else if (w_res_dn) begin
                    if (r_code != '0) w_code_nxt = r_code - C_ONE;
                end
                if (w_res_al) begin
                    w_lock_cnt_nxt = w_lock_inc;
                end else if (w_res_up || w_res_dn) begin
                    w_lock_cnt_nxt = w_same_dir ? 4'd0 : w_lock_inc;
                    w_prev_nxt     = w_res_up ? C_DIR_UP : C_DIR_DN;
                end
            end
            default: w_ctl_nxt = C_ACQ;
        endcase
    end

    assign dco_code = r_code;
    assign up       = r_up;
    assign dn       = r_dn;
    assign acq_done = (r_ctl == C_TRACK);
    assign locked   = r_locked;

endmodule
`default_nettype wire
